// File: rtl/dest_tag_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dest_tag_pipe_pkg : shared widths, forwarding selects and tag type    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package dest_tag_pipe_pkg;

  localparam int RD_W   = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_EX  = 2'b01,
    SEL_MEM = 2'b10,
    SEL_WB  = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            rf_le;
    logic            load;
  } tag_t;

  localparam tag_t BUBBLE_TAG = '{rd: '0, rf_le: 1'b0, load: 1'b0};

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_mux : 4:1 operand select (RF / EX / MEM / WB)                     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fwd_mux
  import dest_tag_pipe_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [1:0]   sel_i,
  input  logic [W-1:0] rf_i,
  input  logic [W-1:0] ex_i,
  input  logic [W-1:0] mem_i,
  input  logic [W-1:0] wb_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = rf_i;
    case (fwd_sel_e'(sel_i))
      SEL_RF:  y_o = rf_i;
      SEL_EX:  y_o = ex_i;
      SEL_MEM: y_o = mem_i;
      SEL_WB:  y_o = wb_i;
      default: y_o = rf_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dest_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dest_tag_pipe : EX/MEM/WB destination-tag pipeline with forwarding    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module dest_tag_pipe
  import dest_tag_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RD_W-1:0]   id_rd,
  input  logic              id_rf_le,
  input  logic              id_load,
  input  logic              id_le,
  input  logic              id_nop,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] ra_rf,
  input  logic [DATA_W-1:0] rb_rf,
  input  logic [1:0]        a_s,
  input  logic [1:0]        b_s,
  output logic [RD_W-1:0]   ex_rd,
  output logic [RD_W-1:0]   mem_rd,
  output logic [RD_W-1:0]   wb_rd,
  output logic              ex_rf_le,
  output logic              mem_rf_le,
  output logic              wb_rf_le,
  output logic              ex_l,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  tag_t              ex_q, ex_d;
  tag_t              mem_q;
  tag_t              wb_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [CNT_W-1:0]  stall_q, stall_d;

  // R0 is never a forwarding source, so its write-enable is dropped at capture.
  always_comb begin
    ex_d = BUBBLE_TAG;
    if (!flush && !id_nop && id_le) begin
      ex_d.rd    = id_rd;
      ex_d.rf_le = id_rf_le && (id_rd != '0);
      ex_d.load  = id_load;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (id_nop && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= BUBBLE_TAG;
      mem_q      <= BUBBLE_TAG;
      wb_q       <= BUBBLE_TAG;
      mem_data_q <= '0;
      wb_data_q  <= '0;
      stall_q    <= '0;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= ex_q;
      wb_q       <= mem_q;
      mem_data_q <= ex_result;
      wb_data_q  <= mem_result;
      stall_q    <= stall_d;
    end
  end

  assign ex_rd     = ex_q.rd;
  assign ex_rf_le  = ex_q.rf_le;
  assign ex_l      = ex_q.load && ex_q.rf_le;
  assign mem_rd    = mem_q.rd;
  assign mem_rf_le = mem_q.rf_le;
  assign wb_rd     = wb_q.rd;
  assign wb_rf_le  = wb_q.rf_le;
  assign wb_data   = wb_data_q;
  assign stall_cnt = stall_q;

  fwd_mux #(.W(DATA_W)) u_fwd_a (
    .sel_i (a_s),
    .rf_i  (ra_rf),
    .ex_i  (ex_result),
    .mem_i (mem_result),
    .wb_i  (wb_data_q),
    .y_o   (op_a)
  );

  fwd_mux #(.W(DATA_W)) u_fwd_b (
    .sel_i (b_s),
    .rf_i  (rb_rf),
    .ex_i  (ex_result),
    .mem_i (mem_result),
    .wb_i  (wb_data_q),
    .y_o   (op_b)
  );

endmodule
`default_nettype wire

// File: tb/tb_dest_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dest_tag_pipe : scoreboard bench for dest_tag_pipe                 |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_dest_tag_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rd = '0;
  logic        id_rf_le = 1'b0, id_load = 1'b0, id_le = 1'b0, id_nop = 1'b0, flush = 1'b0;
  logic [31:0] ex_result = '0, mem_result = '0, ra_rf = '0, rb_rf = '0;
  logic [1:0]  a_s = 2'b00, b_s = 2'b00;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_rf_le, mem_rf_le, wb_rf_le, ex_l;
  logic [31:0] op_a, op_b, wb_data;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic [4:0] rd;
    logic       rf_le;
    logic       load;
  } exp_tag_t;

  exp_tag_t    tag_q[$];
  logic [31:0] wbd_q[$];
  int          exp_stall;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  dest_tag_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .id_rd(id_rd), .id_rf_le(id_rf_le), .id_load(id_load),
    .id_le(id_le), .id_nop(id_nop), .flush(flush),
    .ex_result(ex_result), .mem_result(mem_result), .ra_rf(ra_rf), .rb_rf(rb_rf),
    .a_s(a_s), .b_s(b_s),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rf_le(ex_rf_le), .mem_rf_le(mem_rf_le), .wb_rf_le(wb_rf_le), .ex_l(ex_l),
    .op_a(op_a), .op_b(op_b), .wb_data(wb_data), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic reset_model();
    tag_q.delete();
    wbd_q.delete();
    repeat (3) tag_q.push_back('0);
    exp_stall = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ex_rd"}, 32'(ex_rd), 0);
    check({tag, ".ex_rf_le"}, 32'(ex_rf_le), 0);
    check({tag, ".ex_l"}, 32'(ex_l), 0);
    check({tag, ".mem_rd"}, 32'(mem_rd), 0);
    check({tag, ".mem_rf_le"}, 32'(mem_rf_le), 0);
    check({tag, ".wb_rd"}, 32'(wb_rd), 0);
    check({tag, ".wb_rf_le"}, 32'(wb_rf_le), 0);
    check({tag, ".wb_data"}, wb_data, 0);
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 0);
  endtask

  // Push the expectation for the current inputs, clock once, pop and compare.
  task automatic step(input string tag);
    exp_tag_t    e;
    logic [31:0] wexp;
    e = '0;
    if (!flush && !id_nop && id_le) begin
      e.rd    = id_rd;
      e.rf_le = id_rf_le && (id_rd != 5'd0);
      e.load  = id_load;
    end
    tag_q.push_back(e);
    wbd_q.push_back(mem_result);
    if (id_nop && !flush && exp_stall < 65535) exp_stall++;
    @(posedge clk);
    #1;
    void'(tag_q.pop_front());
    wexp = wbd_q.pop_front();
    check({tag, ".ex_rd"}, 32'(ex_rd), 32'(tag_q[2].rd));
    check({tag, ".ex_rf_le"}, 32'(ex_rf_le), 32'(tag_q[2].rf_le));
    check({tag, ".ex_l"}, 32'(ex_l), 32'(tag_q[2].rf_le & tag_q[2].load));
    check({tag, ".mem_rd"}, 32'(mem_rd), 32'(tag_q[1].rd));
    check({tag, ".mem_rf_le"}, 32'(mem_rf_le), 32'(tag_q[1].rf_le));
    check({tag, ".wb_rd"}, 32'(wb_rd), 32'(tag_q[0].rd));
    check({tag, ".wb_rf_le"}, 32'(wb_rf_le), 32'(tag_q[0].rf_le));
    check({tag, ".wb_data"}, wb_data, wexp);
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
  endtask

  task automatic drive_id(input logic [4:0] rd, input logic rfle, input logic ld,
                          input logic le, input logic nop, input logic fl);
    id_rd = rd; id_rf_le = rfle; id_load = ld; id_le = le; id_nop = nop; flush = fl;
  endtask

  initial begin
    ra_rf = 32'h1234;
    rb_rf = 32'h5678;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    check("rst.op_a", op_a, 32'h1234);
    check("rst.op_b", op_b, 32'h5678);
    rst_n = 1'b1;
    reset_model();

    drive_id(5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("cap1");
    check("cap1.ex_rd5", 32'(ex_rd), 5);
    check("cap1.ex_rf_le1", 32'(ex_rf_le), 1);

    drive_id(5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("r0");
    check("r0.ex_rf_le", 32'(ex_rf_le), 0);
    check("r0.ex_l", 32'(ex_l), 0);
    check("cap2.mem_rd5", 32'(mem_rd), 5);

    drive_id(5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("ld");
    check("ld.ex_l", 32'(ex_l), 1);
    check("cap3.wb_rd5", 32'(wb_rd), 5);

    drive_id(5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("stall");
    check("stall.ex_rd", 32'(ex_rd), 0);
    check("stall.mem_rd7", 32'(mem_rd), 7);
    check("stall.cnt1", 32'(stall_cnt), 1);

    drive_id(5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step("flush");
    check("flush.ex_rf_le", 32'(ex_rf_le), 0);
    check("flush.cnt1", 32'(stall_cnt), 1);

    drive_id(5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hold");
    check("hold.ex_rf_le", 32'(ex_rf_le), 0);

    for (int i = 0; i < 40; i++) begin
      drive_id(5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 5) == 0));
      ex_result  = $urandom;
      mem_result = $urandom;
      step("rand");
    end

    drive_id(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex_result  = 32'hA;
    mem_result = 32'hB;
    step("fwd");
    mem_result = 32'hD;
    ra_rf = 32'hC;
    rb_rf = 32'hE;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] ea, eb;
      a_s = 2'(s);
      b_s = 2'(3 - s);
      #1;
      ea = (s == 0) ? 32'hC : (s == 1) ? 32'hA : (s == 2) ? 32'hD : 32'hB;
      eb = (s == 3) ? 32'hE : (s == 2) ? 32'hA : (s == 1) ? 32'hD : 32'hB;
      check($sformatf("fwd.op_a%0d", s), op_a, ea);
      check($sformatf("fwd.op_b%0d", 3 - s), op_b, eb);
    end
    a_s = 2'b00;
    b_s = 2'b00;

    drive_id(5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    while (exp_stall < 16'hFFFE) step("sat_fill");
    check("sat.cnt_fffe", 32'(stall_cnt), 32'hFFFE);
    repeat (3) step("sat");
    check("sat.cnt_ffff", 32'(stall_cnt), 32'hFFFF);

    for (int i = 0; i < 3; i++) begin
      drive_id(5'(i + 10), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      mem_result = 32'hCAFE0000 + 32'(i);
      step("pre_rst");
    end
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    check("midrst.op_a", op_a, 32'hC);
    @(posedge clk);
    #1;
    check_all_zero("midrst_hold");
    rst_n = 1'b1;
    reset_model();
    drive_id(5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("post_rst1");
    check("post_rst1.ex_rd", 32'(ex_rd), 12);
    drive_id(5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("post_rst2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dest_tag_pipe.md
DEST_TAG_PIPE -- requirements
Module: dest_tag_pipe

Interface
REQ-001 SHALL have ports: clk in 1 (rising-edge clock); rst_n in 1 (reset, asynchronous, active-low); one clock, no other clock or reset inputs.
REQ-002 SHALL have inputs: id_rd 5 (ID destination register); id_rf_le 1 (ID instruction writes RF); id_load 1 (ID instruction is a load).
REQ-003 SHALL have inputs: id_le 1 (ID advance enable from hazard unit); id_nop 1 (bubble request from hazard unit); flush 1 (squash the instruction entering EX).
REQ-004 SHALL have inputs: ex_result 32 (ALU result in EX); mem_result 32 (load data or pass-through value in MEM); ra_rf 32 and rb_rf 32 (register-file read data).
REQ-005 SHALL have forwarding-select inputs: a_s 2 and b_s 2, where 00 = RF, 01 = EX, 10 = MEM, 11 = WB.
REQ-006 SHALL have outputs: ex_rd, mem_rd, wb_rd 5 each; ex_rf_le, mem_rf_le, wb_rf_le 1 each; ex_l 1 (EX holds a load).
REQ-007 SHALL have outputs: op_a 32 and op_b 32 (forwarded operands); wb_data 32 (registered WB value); stall_cnt 16 (bubble-cycle counter).

Function
REQ-008 SHALL implement three tag stages EX, MEM and WB; each stage holds {rd 5, rf_le 1, load 1}.
REQ-009 On every rising clk edge, WB SHALL load MEM and MEM SHALL load EX, unconditionally.
REQ-010 EX SHALL load {id_rd, id_rf_le, id_load} only when id_le=1, id_nop=0 and flush=0.
REQ-011 Otherwise EX SHALL load a bubble {rd=0, rf_le=0, load=0}; priority is flush > id_nop > !id_le.
REQ-012 An entry captured with id_rd=0 SHALL have rf_le forced to 0, because R0 is never a forwarding source.
REQ-013 ex_l SHALL equal EX.load AND EX.rf_le; a load to R0 SHALL NOT raise ex_l.
REQ-014 A MEM data register SHALL capture ex_result each edge; wb_data SHALL capture mem_result each edge.
REQ-015 Every stage output SHALL be the corresponding register value; the tag path has 1-cycle latency per stage.
REQ-016 op_a SHALL be combinational from a_s: 00 ra_rf, 01 ex_result, 10 mem_result, 11 wb_data.
REQ-017 op_b SHALL be selected from b_s in the same way, using rb_rf for 00.
REQ-018 stall_cnt SHALL increment by 1 on each edge with id_nop=1 and flush=0, and SHALL saturate at 0xFFFF with no wrap.
REQ-019 When flush and id_nop are asserted together, the cycle SHALL count as a flush and SHALL NOT increment stall_cnt.
REQ-020 id_le=0 with id_nop=0 SHALL still insert a bubble into EX, so that EX never duplicates an instruction.

Reset
REQ-021 rst_n low SHALL immediately clear every stage to a bubble (rd=0, rf_le=0, load=0), independent of clk.
REQ-022 During reset, every registered output SHALL read 0: all rd and rf_le outputs, ex_l, wb_data, the MEM data register and stall_cnt.
REQ-023 op_a and op_b remain combinational during reset; with a_s=b_s=00 they SHALL pass ra_rf and rb_rf.
REQ-024 Reset asserted mid-pipeline SHALL discard all in-flight tags and data; the first edge after deassertion SHALL follow REQ-009 to REQ-011.

Structure
REQ-025 The forwarding-select encodings (RF/EX/MEM/WB), the bubble tag constant and the widths (RD 5, DATA 32, CNT 16) SHALL be defined in the shared pipeline package.
REQ-026 The identical 4:1 operand select SHALL be one sub-module, fwd_mux, instantiated twice (A and B).
REQ-027 The block SHALL contain no latches, and all state SHALL be in one clocked process with asynchronous rst_n.

Verification
REQ-028 Capture: id_rd=5, id_rf_le=1, id_le=1, id_nop=0 -> ex_rd=5 and ex_rf_le=1 after edge 1, mem_rd=5 after edge 2, wb_rd=5 after edge 3.
REQ-029 R0: id_rd=0, id_rf_le=1, id_load=1 -> after 1 edge, ex_rd=0, ex_rf_le=0 and ex_l=0.
REQ-030 Load stall: id_load=1, id_rd=7, then id_nop=1 and id_le=0 for 1 cycle -> ex_l=1 after edge 1, EX is a bubble after edge 2, mem_rd=7, stall_cnt=1.
REQ-031 Flush priority: flush=1 and id_nop=1 with id_rd=9 -> EX is a bubble and stall_cnt is unchanged.
REQ-032 Forwarding: ex_result=0xA, mem_result=0xB (then latched), ra_rf=0xC -> op_a is 0xC, 0xA, 0xB and wb_data for a_s = 00, 01, 10 and 11 respectively.
REQ-033 Saturation and reset: preload stall_cnt to 0xFFFE, hold id_nop=1 for 3 edges -> stall_cnt stays at 0xFFFF; rst_n low mid-clock -> all registered outputs read 0 immediately, before the next edge.
